// File: rtl/cache_pkg.sv
// Shared types and field-width helpers for the direct-mapped data cache.
package cache_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    function automatic int unsigned off_width(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_width(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_width(input int unsigned line_words, input int unsigned sets);
        return ADDR_W - off_width(line_words) - idx_width(sets) - 2;
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side buses of the data cache controller.
interface cpu_bus_if;
    import cache_pkg::*;

    logic              cpu_ren;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cache_rdy;

    modport master (output cpu_ren, cpu_wen, cpu_addr, cpu_din, input cpu_dout, cache_rdy);
    modport slave  (input cpu_ren, cpu_wen, cpu_addr, cpu_din, output cpu_dout, cache_rdy);
endinterface

interface mem_bus_if;
    import cache_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem_din;
    logic              mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_dout, input mem_din, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_dout, output mem_din, mem_ack);
endinterface

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data storage: combinational read, synchronous word write.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 64,
    localparam int unsigned OFF_W     = off_width(LINE_WORDS),
    localparam int unsigned IDX_W     = idx_width(SETS),
    localparam int unsigned TAG_W     = tag_width(LINE_WORDS, SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_word,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  tag_wdata,
    input  logic              set_valid,
    input  logic              set_dirty,
    input  logic              clr_dirty
);

    logic [DATA_W-1:0] data_mem [SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_data  = data_mem[rd_idx][rd_word];

    // Set takes precedence over clear on the same line.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (set_valid) valid_d[wr_idx] = 1'b1;
        if (clr_dirty) dirty_d[wr_idx] = 1'b0;
        if (set_dirty) dirty_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tags survive reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (wr_en)  data_mem[wr_idx][wr_word] <= wr_data;
        if (tag_we) tag_mem[wr_idx]           <= tag_wdata;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with a
// burst sequencer for line write-back and refill.
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 64
) (
    input  logic clk,
    input  logic rst,
    cpu_bus_if.slave  cpu,
    mem_bus_if.master mem
);

    localparam int unsigned OFF_W = off_width(LINE_WORDS);
    localparam int unsigned IDX_W = idx_width(SETS);
    localparam int unsigned TAG_W = tag_width(LINE_WORDS, SETS);

    state_e                   state_q, state_d;
    logic [OFF_W-1:0]         beat_q, beat_d;
    logic [TAG_W+IDX_W-1:0]   req_line_q, req_line_d;

    logic [OFF_W-1:0]  cpu_word;
    logic [IDX_W-1:0]  cpu_idx, req_idx;
    logic [TAG_W-1:0]  cpu_tag, req_tag;
    logic              unused_addr_bits;

    logic [IDX_W-1:0]  rd_idx;
    logic [OFF_W-1:0]  rd_word;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid, rd_dirty;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en, tag_we, set_valid, set_dirty, clr_dirty;
    logic [IDX_W-1:0]  wr_idx;
    logic [OFF_W-1:0]  wr_word;
    logic [DATA_W-1:0] wr_data;
    logic              hit, last_beat;

    assign cpu_word         = cpu.cpu_addr[OFF_W+1:2];
    assign cpu_idx          = cpu.cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign cpu_tag          = cpu.cpu_addr[ADDR_W-1:OFF_W+IDX_W+2];
    assign unused_addr_bits = ^cpu.cpu_addr[1:0];
    assign req_idx          = req_line_q[IDX_W-1:0];
    assign req_tag          = req_line_q[TAG_W+IDX_W-1:IDX_W];

    // In IDLE the store looks up the live request; during a burst it follows the latched line.
    assign rd_idx    = (state_q == IDLE) ? cpu_idx  : req_idx;
    assign rd_word   = (state_q == IDLE) ? cpu_word : beat_q;
    assign hit       = rd_valid && (rd_tag == cpu_tag);
    assign last_beat = (beat_q == OFF_W'(LINE_WORDS - 1));

    cache_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_word   (rd_word),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .tag_we    (tag_we),
        .tag_wdata (req_tag),
        .set_valid (set_valid),
        .set_dirty (set_dirty),
        .clr_dirty (clr_dirty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            req_line_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            req_line_q <= req_line_d;
        end
    end

    // Next state, store control and bus outputs.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        req_line_d    = req_line_q;
        cpu.cache_rdy = 1'b1;
        cpu.cpu_dout  = '0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_dout  = '0;
        wr_en         = 1'b0;
        wr_idx        = req_idx;
        wr_word       = beat_q;
        wr_data       = mem.mem_din;
        tag_we        = 1'b0;
        set_valid     = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu.cpu_wen || cpu.cpu_ren) begin
                    if (hit) begin
                        if (cpu.cpu_wen) begin
                            wr_en     = 1'b1;
                            wr_idx    = cpu_idx;
                            wr_word   = cpu_word;
                            wr_data   = cpu.cpu_din;
                            set_dirty = 1'b1;
                        end else begin
                            cpu.cpu_dout = rd_data;
                        end
                    end else begin
                        cpu.cache_rdy = 1'b0;
                        req_line_d    = {cpu_tag, cpu_idx};
                        beat_d        = '0;
                        state_d       = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                cpu.cache_rdy = 1'b0;
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {rd_tag, req_idx, beat_q, 2'b00};
                mem.mem_dout  = rd_data;
                if (mem.mem_ack) begin
                    beat_d = beat_q + OFF_W'(1);
                    if (last_beat) begin
                        clr_dirty = 1'b1;
                        state_d   = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                cpu.cache_rdy = 1'b0;
                mem.mem_req   = 1'b1;
                mem.mem_addr  = {req_tag, req_idx, beat_q, 2'b00};
                if (mem.mem_ack) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + OFF_W'(1);
                    if (last_beat) begin
                        tag_we    = 1'b1;
                        set_valid = 1'b1;
                        clr_dirty = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a 2-cycle-latency memory model.
module tb_dcache_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_bus_if cpu_if ();
    mem_bus_if mem_if ();

    dcache_ctrl #(
        .LINE_WORDS (4),
        .SETS       (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cpu (cpu_if),
        .mem (mem_if)
    );

    typedef struct {
        bit          we;
        bit          re;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        int          exp_wb;
        int          exp_rd;
        logic [31:0] exp_wb_base;
        logic [31:0] exp_wb_w1;
        logic [31:0] exp_rd_base;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] wb_addr [$];
    logic [31:0] wb_data [$];
    logic [31:0] rd_addr [$];
    logic [31:0] got_dout;
    logic        first_mem_req;
    int          got_cycles;

    vec_t vecs [13];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return 32'hA000_0000 | a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request and act as memory until cache_rdy, or until stop_wb write beats were acked.
    task automatic do_req(input bit we, input bit re, input logic [31:0] addr,
                          input logic [31:0] din, input int stop_wb);
        int wait_cnt;
        bit timed_out;
        wait_cnt  = 0;
        timed_out = 1'b0;
        got_cycles = 0;
        wb_addr.delete();
        wb_data.delete();
        rd_addr.delete();
        @(negedge clk);
        cpu_if.cpu_wen  = we;
        cpu_if.cpu_ren  = re;
        cpu_if.cpu_addr = addr;
        cpu_if.cpu_din  = din;
        #1;
        first_mem_req = mem_if.mem_req;
        while (1) begin
            if (cpu_if.cache_rdy) break;
            if (got_cycles >= 400) begin
                timed_out = 1'b1;
                break;
            end
            if (mem_if.mem_req) begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    wait_cnt = 0;
                    if (mem_if.mem_we) begin
                        wb_addr.push_back(mem_if.mem_addr);
                        wb_data.push_back(mem_if.mem_dout);
                        mem_arr[mem_if.mem_addr] = mem_if.mem_dout;
                    end else begin
                        rd_addr.push_back(mem_if.mem_addr);
                        mem_if.mem_din = mem_val(mem_if.mem_addr);
                    end
                    mem_if.mem_ack = 1'b1;
                end
            end
            if (stop_wb != 0 && wb_addr.size() == stop_wb) break;
            @(negedge clk);
            mem_if.mem_ack = 1'b0;
            #1;
            got_cycles++;
        end
        got_dout = cpu_if.cpu_dout;
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL timeout addr 0x%08h: cache_rdy not seen in 400 cycles", addr);
        end
    endtask

    initial begin
        rst             = 1'b1;
        cpu_if.cpu_ren  = 1'b0;
        cpu_if.cpu_wen  = 1'b0;
        cpu_if.cpu_addr = '0;
        cpu_if.cpu_din  = '0;
        mem_if.mem_ack  = 1'b0;
        mem_if.mem_din  = '0;

        //        we re addr          din           dout          wb rd wb_base      wb_w1         rd_base
        vecs[0]  = '{0, 1, 32'h40,  32'h0,        32'hA000_0040, 0, 4, 32'h0,  32'h0,        32'h40};
        vecs[1]  = '{0, 1, 32'h44,  32'h0,        32'hA000_0044, 0, 0, 32'h0,  32'h0,        32'h0};
        vecs[2]  = '{1, 0, 32'h44,  32'hDEADBEEF, 32'h0,         0, 0, 32'h0,  32'h0,        32'h0};
        vecs[3]  = '{0, 1, 32'h44,  32'h0,        32'hDEADBEEF,  0, 0, 32'h0,  32'h0,        32'h0};
        vecs[4]  = '{0, 1, 32'h440, 32'h0,        32'hA000_0440, 4, 4, 32'h40, 32'hDEADBEEF, 32'h440};
        vecs[5]  = '{0, 1, 32'h40,  32'h0,        32'hA000_0040, 0, 4, 32'h0,  32'h0,        32'h40};
        vecs[6]  = '{0, 1, 32'h44,  32'h0,        32'hDEADBEEF,  0, 0, 32'h0,  32'h0,        32'h0};
        vecs[7]  = '{1, 0, 32'h80,  32'h12345678, 32'h0,         0, 4, 32'h0,  32'h0,        32'h80};
        vecs[8]  = '{0, 1, 32'h80,  32'h0,        32'h12345678,  0, 0, 32'h0,  32'h0,        32'h0};
        vecs[9]  = '{0, 1, 32'h84,  32'h0,        32'hA000_0084, 0, 0, 32'h0,  32'h0,        32'h0};
        vecs[10] = '{1, 1, 32'h88,  32'h0BADF00D, 32'h0,         0, 0, 32'h0,  32'h0,        32'h0};
        vecs[11] = '{0, 1, 32'h88,  32'h0,        32'h0BADF00D,  0, 0, 32'h0,  32'h0,        32'h0};
        vecs[12] = '{0, 1, 32'h880, 32'h0,        32'hA000_0880, 4, 4, 32'h80, 32'hA000_0084, 32'h880};

        repeat (2) @(negedge clk);
        #1;
        check("reset cache_rdy", 32'(cpu_if.cache_rdy), 32'd1);
        check("reset mem_req",   32'(mem_if.mem_req),   32'd0);
        check("reset mem_we",    32'(mem_if.mem_we),    32'd0);
        check("reset mem_addr",  mem_if.mem_addr,       32'h0);
        check("reset mem_dout",  mem_if.mem_dout,       32'h0);
        check("reset cpu_dout",  cpu_if.cpu_dout,       32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_req(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].din, 0);
            check($sformatf("v%0d dout", i), got_dout, vecs[i].exp_dout);
            check($sformatf("v%0d wb beats", i), 32'(wb_addr.size()), 32'(vecs[i].exp_wb));
            check($sformatf("v%0d rd beats", i), 32'(rd_addr.size()), 32'(vecs[i].exp_rd));
            for (int k = 0; k < wb_addr.size() && k < vecs[i].exp_wb; k++)
                check($sformatf("v%0d wb addr %0d", i, k), wb_addr[k], vecs[i].exp_wb_base + 32'(4 * k));
            if (vecs[i].exp_wb > 1 && wb_data.size() > 1)
                check($sformatf("v%0d wb word1", i), wb_data[1], vecs[i].exp_wb_w1);
            for (int k = 0; k < rd_addr.size() && k < vecs[i].exp_rd; k++)
                check($sformatf("v%0d rd addr %0d", i, k), rd_addr[k], vecs[i].exp_rd_base + 32'(4 * k));
            if (vecs[i].exp_wb == 0 && vecs[i].exp_rd == 0) begin
                check($sformatf("v%0d hit latency", i), 32'(got_cycles), 32'd0);
                check($sformatf("v%0d hit mem_req", i), 32'(first_mem_req), 32'd0);
            end
        end

        // Dirty the resident 0x880 line, then reset after two write-back beats.
        do_req(1'b1, 1'b0, 32'h884, 32'h1111_2222, 0);
        check("rst seq write hit latency", 32'(got_cycles), 32'd0);
        do_req(1'b0, 1'b1, 32'h080, 32'h0, 2);
        check("rst seq wb beats", 32'(wb_addr.size()), 32'd2);
        if (wb_addr.size() == 2) begin
            check("rst seq wb addr0", wb_addr[0], 32'h880);
            check("rst seq wb addr1", wb_addr[1], 32'h884);
            check("rst seq wb word1", wb_data[1], 32'h1111_2222);
        end
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        rst            = 1'b1;
        cpu_if.cpu_ren = 1'b0;
        cpu_if.cpu_wen = 1'b0;
        @(negedge clk);
        #1;
        check("post-reset mem_req",   32'(mem_if.mem_req),   32'd0);
        check("post-reset cache_rdy", 32'(cpu_if.cache_rdy), 32'd1);
        check("post-reset mem_addr",  mem_if.mem_addr,       32'h0);
        rst = 1'b0;

        do_req(1'b0, 1'b1, 32'h888, 32'h0, 0);
        check("post-reset miss wb beats", 32'(wb_addr.size()), 32'd0);
        check("post-reset miss rd beats", 32'(rd_addr.size()), 32'd4);
        if (rd_addr.size() > 0)
            check("post-reset miss rd addr0", rd_addr[0], 32'h880);
        check("post-reset miss dout", got_dout, mem_val(32'h888));

        @(negedge clk);
        cpu_if.cpu_ren = 1'b0;
        cpu_if.cpu_wen = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
